// File: rtl/gtx_tx_framer_if.sv
// Payload stream handshake into the GTX TX framer.
// The source drives data/valid; the framer returns ready.
interface gtx_tx_framer_if;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/gtx_tx_framer.sv
// GTX TX framer: K28.5 idle fill, SOF, payload (PAD on underrun), optional CRC-16, EOF.
// Define GTX_FRAMER_CRC_EN to include the CRC-16-CCITT word before EOF.
module gtx_tx_framer #(
  parameter int unsigned FRAME_LEN = 64,
  parameter int unsigned IDLE_MIN  = 4
) (
  input  logic                  sys_clk_i,
  input  logic                  sys_rst_ni,
  input  logic                  link_ready_i,
  input  logic                  tx_en_i,
  gtx_tx_framer_if.slave        s_if,
  output logic [15:0]           tx_data_o,
  output logic [1:0]            tx_charisk_o,
  output logic                  frame_active_o,
  output logic [7:0]            seq_num_o,
  output logic [15:0]           underrun_cnt_o
);

  localparam logic [15:0] IdleWord = 16'h50BC;
  localparam logic [15:0] PadWord  = 16'h1C1C;
  localparam logic [15:0] EofWord  = 16'h00FD;
  localparam logic [15:0] LastIdx  = 16'(FRAME_LEN - 1);
  localparam logic [7:0]  IdleMin  = 8'(IDLE_MIN);

`ifdef GTX_FRAMER_CRC_EN
  typedef enum logic [2:0] {StIdle, StSof, StPayload, StCrc, StEof} state_e;
`else
  typedef enum logic [2:0] {StIdle, StSof, StPayload, StEof} state_e;
`endif

  state_e      state_q;
  logic [15:0] tx_data_q;
  logic [1:0]  tx_charisk_q;
  logic [7:0]  seq_q;
  logic [15:0] underrun_q;
  logic [7:0]  idle_cnt_q;
  logic [7:0]  idle_cnt_inc;
  logic [15:0] word_cnt_q;

`ifdef GTX_FRAMER_CRC_EN
  logic [15:0] crc_q;
  logic [15:0] crc_next;

  // MSB-first CRC-16-CCITT over one 16-bit word.
  function automatic logic [15:0] crc16_step(logic [15:0] crc, logic [15:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 15; i >= 0; i--) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_next = crc16_step(crc_q, s_if.s_data);
`endif

  // Count includes the IDLE word emitted this cycle, so exactly IdleMin words precede SOF.
  assign idle_cnt_inc = (idle_cnt_q == 8'hFF) ? 8'hFF : idle_cnt_q + 8'd1;

  assign s_if.s_ready   = (state_q == StPayload) && link_ready_i;
  assign frame_active_o = (state_q != StIdle);
  assign tx_data_o      = tx_data_q;
  assign tx_charisk_o   = tx_charisk_q;
  assign seq_num_o      = seq_q;
  assign underrun_cnt_o = underrun_q;

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      state_q      <= StIdle;
      tx_data_q    <= IdleWord;
      tx_charisk_q <= 2'b01;
      seq_q        <= '0;
      underrun_q   <= '0;
      idle_cnt_q   <= '0;
      word_cnt_q   <= '0;
`ifdef GTX_FRAMER_CRC_EN
      crc_q        <= 16'hFFFF;
`endif
    end else if (!link_ready_i) begin
      // Link loss aborts any frame; the sequence number is kept for the retry.
      state_q      <= StIdle;
      tx_data_q    <= IdleWord;
      tx_charisk_q <= 2'b01;
      idle_cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          tx_data_q    <= IdleWord;
          tx_charisk_q <= 2'b01;
          idle_cnt_q   <= idle_cnt_inc;
          if ((idle_cnt_inc >= IdleMin) && tx_en_i && s_if.s_valid) state_q <= StSof;
        end
        StSof: begin
          tx_data_q    <= {seq_q, 8'hFB};
          tx_charisk_q <= 2'b01;
          word_cnt_q   <= '0;
`ifdef GTX_FRAMER_CRC_EN
          crc_q        <= 16'hFFFF;
`endif
          state_q      <= StPayload;
        end
        StPayload: begin
          if (s_if.s_valid) begin
            tx_data_q    <= s_if.s_data;
            tx_charisk_q <= 2'b00;
            word_cnt_q   <= word_cnt_q + 16'd1;
`ifdef GTX_FRAMER_CRC_EN
            crc_q        <= crc_next;
            if (word_cnt_q == LastIdx) state_q <= StCrc;
`else
            if (word_cnt_q == LastIdx) state_q <= StEof;
`endif
          end else begin
            tx_data_q    <= PadWord;
            tx_charisk_q <= 2'b11;
            if (underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
          end
        end
`ifdef GTX_FRAMER_CRC_EN
        StCrc: begin
          tx_data_q    <= crc_q;
          tx_charisk_q <= 2'b00;
          state_q      <= StEof;
        end
`endif
        StEof: begin
          tx_data_q    <= EofWord;
          tx_charisk_q <= 2'b01;
          seq_q        <= seq_q + 8'd1;
          idle_cnt_q   <= '0;
          state_q      <= StIdle;
        end
        default: begin
          tx_data_q    <= IdleWord;
          tx_charisk_q <= 2'b01;
          state_q      <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gtx_tx_framer.sv
// Self-checking bench for gtx_tx_framer: scripted frames on a FRAME_LEN=4 instance and a
// vector table on a FRAME_LEN=2 instance; expected words go through a scoreboard queue.
module tb_gtx_tx_framer;

  localparam int FL = 4;
  localparam int IM = 4;
  localparam logic [15:0] IdleW = 16'h50BC;
  localparam logic [15:0] PadW  = 16'h1C1C;
  localparam logic [15:0] EofW  = 16'h00FD;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Main instance
  logic        link_ready = 1'b0, tx_en = 1'b0;
  logic [15:0] tx_data, underrun_cnt;
  logic [1:0]  tx_charisk;
  logic        frame_active;
  logic [7:0]  seq_num;
  gtx_tx_framer_if s_if ();

  gtx_tx_framer #(.FRAME_LEN(FL), .IDLE_MIN(IM)) dut (
    .sys_clk_i      (clk),
    .sys_rst_ni     (rst_n),
    .link_ready_i   (link_ready),
    .tx_en_i        (tx_en),
    .s_if           (s_if.slave),
    .tx_data_o      (tx_data),
    .tx_charisk_o   (tx_charisk),
    .frame_active_o (frame_active),
    .seq_num_o      (seq_num),
    .underrun_cnt_o (underrun_cnt)
  );

  // Short-frame instance
  logic        d2_link = 1'b0, d2_en = 1'b0;
  logic [15:0] d2_data, d2_underrun;
  logic [1:0]  d2_k;
  logic        d2_active;
  logic [7:0]  d2_seq;
  gtx_tx_framer_if s2_if ();

  gtx_tx_framer #(.FRAME_LEN(2), .IDLE_MIN(1)) dut2 (
    .sys_clk_i      (clk),
    .sys_rst_ni     (rst_n),
    .link_ready_i   (d2_link),
    .tx_en_i        (d2_en),
    .s_if           (s2_if.slave),
    .tx_data_o      (d2_data),
    .tx_charisk_o   (d2_k),
    .frame_active_o (d2_active),
    .seq_num_o      (d2_seq),
    .underrun_cnt_o (d2_underrun)
  );

  typedef struct {
    logic [15:0] d;
    logic [1:0]  k;
    string       nm;
  } exp_t;

  typedef struct {
    logic        link;
    logic        en;
    logic        valid;
    logic [15:0] data;
    logic [15:0] exp_d;
    logic [1:0]  exp_k;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_seq = 8'd0;
  logic [15:0] exp_underrun = 16'd0;
  logic [15:0] next_data = 16'd0;

  function automatic logic [15:0] crc_model(logic [15:0] c, logic [15:0] d);
    logic [15:0] r;
    r = c ^ d;
    for (int i = 0; i < 16; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic pop_cmp(input logic [15:0] act_d, input logic [1:0] act_k);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(e.nm, {14'd0, act_k, act_d}, {14'd0, e.k, e.d});
    end
  endtask

  task automatic set_in(input logic link, input logic en, input logic valid,
                        input logic [15:0] data);
    link_ready     = link;
    tx_en          = en;
    s_if.s_valid   = valid;
    s_if.s_data    = data;
  endtask

  // Push expectation for the word emitted this cycle, clock, then compare.
  task automatic tick(input logic [15:0] ew, input logic [1:0] ek, input string nm);
    sb.push_back('{d: ew, k: ek, nm: nm});
    @(posedge clk);
    #1;
    pop_cmp(tx_data, tx_charisk);
  endtask

  task automatic drive(input logic link, input logic en, input logic valid,
                       input logic [15:0] data, input logic [15:0] ew, input logic [1:0] ek,
                       input string nm);
    set_in(link, en, valid, data);
    tick(ew, ek, nm);
  endtask

  task automatic idles_then_sof();
    for (int i = 0; i < IM; i++) drive(1'b1, 1'b1, 1'b1, next_data, IdleW, 2'b01, "idle");
    drive(1'b1, 1'b1, 1'b1, next_data, {exp_seq, 8'hFB}, 2'b01, "sof");
  endtask

  task automatic run_frame(input int gap_at, input int gap_len, input logic en_body);
    logic [15:0] crc;
    int          w;
    int          gaps;
    crc  = 16'hFFFF;
    w    = 0;
    gaps = gap_len;
    idles_then_sof();
    while (w < FL) begin
      if (w == gap_at && gaps > 0) begin
        drive(1'b1, en_body, 1'b0, 16'hDEAD, PadW, 2'b11, "pad");
        gaps--;
        exp_underrun++;
      end else begin
        drive(1'b1, en_body, 1'b1, next_data, next_data, 2'b00, "data");
        crc = crc_model(crc, next_data);
        next_data++;
        w++;
      end
    end
`ifdef GTX_FRAMER_CRC_EN
    drive(1'b1, en_body, 1'b0, 16'h0, crc, 2'b00, "crc");
`endif
    drive(1'b1, en_body, 1'b0, 16'h0, EofW, 2'b01, "eof");
    exp_seq++;
    chk("seq_num_after_eof", {24'd0, seq_num}, {24'd0, exp_seq});
    chk("underrun_cnt", {16'd0, underrun_cnt}, {16'd0, exp_underrun});
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_tx_data", {16'd0, tx_data}, {16'd0, IdleW});
    chk("rst_charisk", {30'd0, tx_charisk}, 32'd1);
    chk("rst_frame_active", {31'd0, frame_active}, 32'd0);
    chk("rst_s_ready", {31'd0, s_if.s_ready}, 32'd0);
    chk("rst_seq_num", {24'd0, seq_num}, 32'd0);
    chk("rst_underrun", {16'd0, underrun_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_seq      = 8'd0;
    exp_underrun = 16'd0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c2;
    set_in(1'b1, 1'b0, 1'b0, 16'h0);
    s2_if.s_valid = 1'b0;
    s2_if.s_data  = 16'h0;
    d2_link = 1'b1;
    do_reset();

    // Short frame, FRAME_LEN=2, IDLE_MIN=1: SOF, D, D, [CRC,] EOF.
    c2 = crc_model(crc_model(16'hFFFF, 16'hAAAA), 16'h5555);
    vecs.push_back('{1'b1, 1'b1, 1'b1, 16'hAAAA, IdleW,    2'b01});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 16'hAAAA, 16'h00FB, 2'b01});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 16'hAAAA, 16'hAAAA, 2'b00});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'h5555, 16'h5555, 2'b00});
`ifdef GTX_FRAMER_CRC_EN
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0000, c2,       2'b00});
`endif
    vecs.push_back('{1'b1, 1'b0, 1'b0, 16'h0000, EofW,     2'b01});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'h1234, IdleW,    2'b01});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 16'h1234, IdleW,    2'b01});
    foreach (vecs[i]) begin
      d2_link       = vecs[i].link;
      d2_en         = vecs[i].en;
      s2_if.s_valid = vecs[i].valid;
      s2_if.s_data  = vecs[i].data;
      sb.push_back('{d: vecs[i].exp_d, k: vecs[i].exp_k, nm: $sformatf("short_vec%0d", i)});
      @(posedge clk);
      #1;
      pop_cmp(d2_data, d2_k);
    end
    chk("short_seq_num", {24'd0, d2_seq}, 32'd1);
    d2_en = 1'b0;

    // Fresh reset for the main instance so the idle count starts from zero.
    do_reset();
    next_data = 16'd0;

    // Clean frame with data 0..3.
    run_frame(-1, 0, 1'b1);
    // Three PAD words mid-payload.
    run_frame(2, 3, 1'b1);
    chk("underrun_is_3", {16'd0, underrun_cnt}, 32'd3);

    // Link drop during payload.
    idles_then_sof();
    drive(1'b1, 1'b1, 1'b1, next_data, next_data, 2'b00, "abort_data0");
    next_data++;
    set_in(1'b1, 1'b1, 1'b1, next_data);
    #1;
    chk("ready_in_payload", {31'd0, s_if.s_ready}, 32'd1);
    chk("active_in_payload", {31'd0, frame_active}, 32'd1);
    tick(next_data, 2'b00, "abort_data1");
    next_data++;
    set_in(1'b0, 1'b1, 1'b1, next_data);
    #1;
    chk("ready_on_link_drop", {31'd0, s_if.s_ready}, 32'd0);
    tick(IdleW, 2'b01, "link_drop_idle");
    chk("active_after_drop", {31'd0, frame_active}, 32'd0);
    chk("seq_after_drop", {24'd0, seq_num}, {24'd0, exp_seq});
    drive(1'b0, 1'b1, 1'b1, next_data, IdleW, 2'b01, "link_low_idle");
    run_frame(-1, 0, 1'b1);

    // Back-to-back frames across the 8-bit sequence wrap.
    for (int f = 0; f < 256; f++) run_frame(-1, 0, 1'b1);

    // Asynchronous reset mid-frame.
    idles_then_sof();
    drive(1'b1, 1'b1, 1'b1, next_data, next_data, 2'b00, "pre_reset_data");
    next_data++;
    chk("seq_nonzero_pre_reset", {24'd0, seq_num}, {24'd0, exp_seq});
    do_reset();

    // tx_en dropped right after SOF: frame finishes, no new SOF.
    run_frame(-1, 0, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b1, next_data, IdleW, 2'b01, "no_new_sof");
    chk("inactive_after_en_drop", {31'd0, frame_active}, 32'd0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
